// File: rtl/palette_fader_if.sv
// palette_fader_if: pixel lookup, fade control and palette write bundle for palette_fader
interface palette_fader_if #(
  parameter int IDX_W = 4,
  parameter int CW    = 4,
  parameter int LVL_W = 4
);
  logic [IDX_W-1:0] index;
  logic             pix_valid;
  logic             frame_tick;
  logic             fade_start;
  logic             fade_dir;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [3*CW-1:0]  wr_data;
  logic [CW-1:0]    red;
  logic [CW-1:0]    green;
  logic [CW-1:0]    blue;
  logic             rgb_valid;
  logic             fade_busy;
  logic [LVL_W:0]   fade_level;
  modport slave (
    input  index, pix_valid, frame_tick, fade_start, fade_dir, wr_en, wr_addr, wr_data,
    output red, green, blue, rgb_valid, fade_busy, fade_level
  );
  modport master (
    output index, pix_valid, frame_tick, fade_start, fade_dir, wr_en, wr_addr, wr_data,
    input  red, green, blue, rgb_valid, fade_busy, fade_level
  );
endinterface

// File: rtl/palette_fader.sv
// palette_fader: palette lookup with frame-timed brightness fade; define PALETTE_FADER_WR_EN for a writable palette
module palette_fader #(
  parameter int IDX_W       = 4,
  parameter int CW          = 4,
  parameter int LVL_W       = 4,
  parameter int STEP_FRAMES = 4
) (
  input logic           Clk,
  input logic           Reset_n,
  palette_fader_if.slave bus
);
  localparam int N     = 2 ** IDX_W;
  localparam int MW    = CW + LVL_W + 1;
  localparam int CNT_W = $clog2(STEP_FRAMES + 1);
  localparam logic [LVL_W:0] FULL = (LVL_W + 1)'(2 ** LVL_W);
  typedef enum logic [1:0] {IDLE, FADE_OUT, FADE_IN} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W:0]   lvl_q, lvl_d;
  logic [3*CW-1:0]  rd_entry;
  logic [3*CW-1:0]  s1_q;
  logic             s1_vld_q;
  logic [CW-1:0]    r_q, g_q, b_q;
  logic             vld_q;
  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [LVL_W:0] l);
    logic [MW-1:0] p;
    p = MW'(c) * MW'(l);
    return p[LVL_W +: CW];
  endfunction
`ifdef PALETTE_FADER_WR_EN
  logic [3*CW-1:0] pal_q [N];
  // palette storage: defaults on reset, written at the clock edge so same-cycle reads see the old entry
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n)
      for (int i = 0; i < N; i++) pal_q[i] <= {3{CW'(i)}};
    else if (bus.wr_en)
      pal_q[bus.wr_addr] <= bus.wr_data;
  assign rd_entry = pal_q[bus.index];
`else
  logic [IDX_W+CW-1:0] idx_ext;
  logic                unused_wr;
  assign idx_ext   = {{CW{1'b0}}, bus.index};
  assign rd_entry  = {3{idx_ext[CW-1:0]}};
  assign unused_wr = &{1'b0, bus.wr_en, bus.wr_addr, bus.wr_data};
`endif
  // two-stage lookup: stage 1 fetches the entry, stage 2 scales it by the live fade level
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      vld_q    <= 1'b0;
    end else begin
      s1_q     <= rd_entry;
      s1_vld_q <= bus.pix_valid;
      vld_q    <= s1_vld_q;
      if (s1_vld_q) begin
        r_q <= scale(s1_q[3*CW-1:2*CW], lvl_q);
        g_q <= scale(s1_q[2*CW-1:CW], lvl_q);
        b_q <= scale(s1_q[CW-1:0], lvl_q);
      end
    end
  // fade state, frame counter and brightness registers
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lvl_q   <= FULL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
    end
  // fade sequencing: start only from IDLE, step the level every STEP_FRAMES ticks, stop at the end level
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    case (state_q)
      IDLE:
        if (bus.fade_start && bus.fade_dir && lvl_q != '0) begin
          state_d = FADE_OUT;
          cnt_d   = '0;
        end else if (bus.fade_start && !bus.fade_dir && lvl_q != FULL) begin
          state_d = FADE_IN;
          cnt_d   = '0;
        end
      default:
        if (bus.frame_tick) begin
          if (cnt_q == CNT_W'(STEP_FRAMES - 1)) begin
            cnt_d   = '0;
            lvl_d   = state_q == FADE_OUT ? lvl_q - 1'b1 : lvl_q + 1'b1;
            state_d = (lvl_d == '0 || lvl_d == FULL) ? IDLE : state_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
    endcase
  end
  assign bus.red        = r_q;
  assign bus.green      = g_q;
  assign bus.blue       = b_q;
  assign bus.rgb_valid  = vld_q;
  assign bus.fade_busy  = state_q != IDLE;
  assign bus.fade_level = lvl_q;
endmodule

// File: tb/tb_palette_fader.sv
// tb_palette_fader: directed checks of lookup latency, scaling, fade timing and reset for palette_fader
module tb_palette_fader;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  palette_fader_if #(.IDX_W(4), .CW(4), .LVL_W(4)) bus ();
  palette_fader #(.IDX_W(4), .CW(4), .LVL_W(4), .STEP_FRAMES(4)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge Clk);
    #1;
  endtask
  task automatic chk_rgb(input string tag, input logic [11:0] exp);
    chk(tag, {bus.red, bus.green, bus.blue}, {20'h0, exp});
  endtask
  task automatic pixel(input logic [3:0] idx);
    bus.index     = idx;
    bus.pix_valid = 1'b1;
    step();
    bus.pix_valid = 1'b0;
    chk("lat1_valid", bus.rgb_valid, 0);
    step();
    chk("lat2_valid", bus.rgb_valid, 1);
  endtask
  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    step();
  endtask
  initial begin
    bus.index = '0;
    bus.pix_valid = 1'b0;
    bus.frame_tick = 1'b0;
    bus.fade_start = 1'b0;
    bus.fade_dir = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    #23;
    chk("rst_valid", bus.rgb_valid, 0);
    chk("rst_busy", bus.fade_busy, 0);
    chk("rst_level", bus.fade_level, 16);
    chk_rgb("rst_rgb", 12'h000);
    step();
    Reset_n = 1'b1;
    pixel(4'd5);
    chk_rgb("idx5", 12'h555);
    chk("idx5_level", bus.fade_level, 16);
    step();
    chk("idle_valid", bus.rgb_valid, 0);
    chk_rgb("hold_rgb", 12'h555);
    pixel(4'd12);
    chk_rgb("idx12", 12'hccc);
    pixel(4'd15);
    chk_rgb("idx15", 12'hfff);
`ifdef PALETTE_FADER_WR_EN
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'd3;
    bus.wr_data = 12'hf80;
    bus.index = 4'd3;
    bus.pix_valid = 1'b1;
    step();
    bus.wr_en = 1'b0;
    step();
    bus.pix_valid = 1'b0;
    chk_rgb("wr_old", 12'h333);
    step();
    chk_rgb("wr_new", 12'hf80);
`endif
    bus.fade_start = 1'b1;
    bus.fade_dir = 1'b0;
    step();
    bus.fade_start = 1'b0;
    chk("in_at_full_busy", bus.fade_busy, 0);
    chk("in_at_full_level", bus.fade_level, 16);
    tick();
    chk("idle_tick_level", bus.fade_level, 16);
    bus.fade_start = 1'b1;
    bus.fade_dir = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.fade_start = 1'b0;
    bus.frame_tick = 1'b0;
    chk("out_busy", bus.fade_busy, 1);
    for (int k = 1; k <= 64; k++) begin
      if (k == 33) begin
        bus.fade_start = 1'b1;
        bus.fade_dir = 1'b1;
        step();
        bus.fade_start = 1'b0;
      end
      tick();
      chk($sformatf("out_lvl%0d", k), bus.fade_level, 16 - k / 4);
      if (k == 32) begin
        pixel(4'd15);
        chk_rgb("lvl8_idx15", 12'h777);
      end
      if (k == 63) chk("out_busy63", bus.fade_busy, 1);
    end
    chk("out_done_busy", bus.fade_busy, 0);
    pixel(4'd15);
    chk_rgb("lvl0_idx15", 12'h000);
    bus.fade_start = 1'b1;
    bus.fade_dir = 1'b1;
    step();
    bus.fade_start = 1'b0;
    chk("out_at_zero_busy", bus.fade_busy, 0);
`ifdef PALETTE_FADER_WR_EN
    bus.wr_en = 1'b1;
    bus.wr_addr = 4'd9;
    bus.wr_data = 12'h123;
    step();
    bus.wr_en = 1'b0;
`endif
    bus.fade_start = 1'b1;
    bus.fade_dir = 1'b0;
    step();
    bus.fade_start = 1'b0;
    chk("in_busy", bus.fade_busy, 1);
    for (int k = 1; k <= 24; k++) tick();
    chk("in_lvl6", bus.fade_level, 6);
    bus.index = 4'd7;
    bus.pix_valid = 1'b1;
    step();
    bus.index = 4'd9;
    step();
    bus.pix_valid = 1'b0;
    chk("lvl6_valid", bus.rgb_valid, 1);
    chk_rgb("lvl6_idx7", 12'h222);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.fade_busy, 0);
    chk("mid_rst_level", bus.fade_level, 16);
    chk("mid_rst_valid", bus.rgb_valid, 0);
    chk_rgb("mid_rst_rgb", 12'h000);
    step();
    Reset_n = 1'b1;
    step();
    chk("post_rst_valid1", bus.rgb_valid, 0);
    step();
    chk("post_rst_valid2", bus.rgb_valid, 0);
    pixel(4'd9);
    chk_rgb("post_rst_idx9", 12'h999);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
